sensor_debouncer: RTL and testbench

Two-channel input conditioner that sits directly upstream of the car-parking occupancy FSM. It synchronises the two raw, active-low photo-sensor/button inputs (A = outer, B = inner) into the clock domain and debounces each one independently. It presents clean active-high "beam blocked" levels plus a one-cycle change strobe. The FSM consumes these levels instead of the raw pins, so it sees each sensor edge exactly once.

---
 rtl/sensor_debouncer.sv | 77 +++++++
 tb/tb_sensor_debouncer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debouncer
// Purpose  : Two-channel synchroniser and debouncer for the active-low parking
//            sensors; presents active-high blocked levels plus a change strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debouncer #(
    parameter int THRESHOLD = 500_000,
    parameter int CNT_W     = $clog2(THRESHOLD)
) (
    input  logic clk,
    input  logic reset,
    input  logic a_btn,
    input  logic b_btn,
    output logic a_blocked,
    output logic b_blocked,
    output logic pair_changed
);

    localparam int               c_num_ch  = 2;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [c_num_ch-1:0] w_btn;
    logic [c_num_ch-1:0] w_stable;
    logic [c_num_ch-1:0] w_accept;
    logic                r_pair_changed;

    assign w_btn = {b_btn, a_btn};

    for (genvar i = 0; i < c_num_ch; i++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_stable;
        logic [CNT_W-1:0] r_cnt;

        // Acceptance happens on the edge where the count has already reached its limit.
        assign w_accept[i] = (r_sync2 != r_stable) && (r_cnt == c_cnt_max);
        assign w_stable[i] = r_stable;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync1  <= 1'b1;
                r_sync2  <= 1'b1;
                r_stable <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_btn[i];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

    // Registered on the same edge as the stable levels so all three outputs align.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pair_changed <= 1'b0;
        end else begin
            r_pair_changed <= |w_accept;
        end
    end

    assign a_blocked    = ~w_stable[0];
    assign b_blocked    = ~w_stable[1];
    assign pair_changed = r_pair_changed;

endmodule
`default_nettype wire

// File: tb/tb_sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_debouncer
// Purpose  : Directed self-checking bench for sensor_debouncer (THRESHOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_debouncer;

    localparam int c_threshold = 4;
    localparam int c_latency   = c_threshold + 2;

    logic clk;
    logic reset;
    logic a_btn;
    logic b_btn;
    logic a_blocked;
    logic b_blocked;
    logic pair_changed;

    int tests_run;
    int tests_failed;

    sensor_debouncer #(
        .THRESHOLD (c_threshold)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_btn        (a_btn),
        .b_btn        (b_btn),
        .a_blocked    (a_blocked),
        .b_blocked    (b_blocked),
        .pair_changed (pair_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        reset = 1'b0;
        a_btn = 1'b1;
        b_btn = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got %b expected 000", n, obs);
            end
        end
        reset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_release cycle %0d: got %b expected 000", n, obs);
            end
        end
    endtask

    task automatic test_press_release();
        logic [2:0] obs;
        logic [2:0] exp;
        a_btn = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n >= c_latency), 1'b0, (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL press cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
        a_btn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n < c_latency), 1'b0, (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL release cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] obs;
        logic [2:0] exp;
        b_btn = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            if (n == 4) b_btn = 1'b1;
            tick();
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== 3'b000) begin
                tests_failed++;
                $display("FAIL glitch_short cycle %0d: got %b expected 000", n, obs);
            end
        end
        // Two cycles low, two cycles high, repeated; never long enough to accept.
        for (int n = 0; n < 20; n++) begin
            b_btn = ((n / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== 3'b000) begin
                tests_failed++;
                $display("FAIL bounce cycle %0d: got %b expected 000", n, obs);
            end
        end
        b_btn = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {1'b0, (n >= c_latency), (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL bounce_settle cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
        b_btn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {1'b0, (n < c_latency), (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL bounce_release cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] obs;
        logic [2:0] exp;
        a_btn = 1'b0;
        b_btn = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n >= c_latency), (n >= c_latency), (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL simul_press cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
        a_btn = 1'b1;
        b_btn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n < c_latency), (n < c_latency), (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL simul_release cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_independence();
        logic [2:0] obs;
        logic [2:0] exp;
        a_btn = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            b_btn = ((n - 1) % 3 < 2) ? 1'b0 : 1'b1;
            tick();
            exp = {(n >= c_latency), 1'b0, (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL independence cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
        a_btn = 1'b1;
        b_btn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n < c_latency), 1'b0, (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL independence_release cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [2:0] obs;
        logic [2:0] exp;
        a_btn = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== 3'b000) begin
                tests_failed++;
                $display("FAIL midreset_count cycle %0d: got %b expected 000", n, obs);
            end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        obs = {a_blocked, b_blocked, pair_changed};
        tests_run++;
        if (obs !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset_edge: got %b expected 000", obs);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            exp = {(n >= c_latency), 1'b0, (n == c_latency)};
            obs = {a_blocked, b_blocked, pair_changed};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL midreset_after cycle %0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        a_btn        = 1'b1;
        b_btn        = 1'b1;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_independence();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
